// File: rtl/boot_sequencer_if.sv
// Programmer-side bus of the boot sequencer: download handshake, write
// strobe/address from the UART programmer, and the programmer reset plus
// the steered memory write enables going back out.
interface boot_sequencer_if;
    logic        upg_done_i;
    logic        upg_wen_i;
    logic [14:0] upg_adr_i;
    logic        upg_rst_o;
    logic        rom_wen_o;
    logic        ram_wen_o;

    modport master (
        output upg_done_i,
        output upg_wen_i,
        output upg_adr_i,
        input  upg_rst_o,
        input  rom_wen_o,
        input  ram_wen_o
    );

    modport slave (
        input  upg_done_i,
        input  upg_wen_i,
        input  upg_adr_i,
        output upg_rst_o,
        output rom_wen_o,
        output ram_wen_o
    );
endinterface

// File: rtl/boot_sequencer.sv
// Run/program mode controller for the single-cycle CPU. Debounces the
// program-start button, keeps the UART programmer in reset outside a
// download, holds the CPU in reset while programming, steers programmer
// writes to the instruction ROM or data RAM, and stretches the CPU reset
// for a fixed number of cycles before handing control back to the CPU.
module boot_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start_pg,
    boot_sequencer_if.slave        upg,
    output logic                   cpu_rst_o,
    output logic [1:0]             mode_o,
    output logic [15:0]            word_cnt_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_ARM  = 2'b01,
        ST_PROG = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    localparam logic [19:0] DEB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      state;
    logic [7:0]  hold_cnt;
    logic [1:0]  sync_q;
    logic        sync_lvl;
    logic [19:0] deb_cnt;
    logic        armed;
    logic        press;
    logic        upg_rst_q;
    logic        in_download;

    assign sync_lvl = sync_q[1];

    // A press fires once when the level has been stable for the full window
    // and the button has been released since the previous press.
    assign press = sync_lvl & armed & (deb_cnt == DEB_LAST);

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], start_pg};
        end
    end

    // Count consecutive high cycles; saturate so a held button cannot wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb_cnt <= 20'd0;
        end else if (!sync_lvl) begin
            deb_cnt <= 20'd0;
        end else if (deb_cnt != DEB_LAST) begin
            deb_cnt <= deb_cnt + 20'd1;
        end
    end

    // Re-arm latch: cleared by a press, set again once the button is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed <= 1'b1;
        end else if (!sync_lvl) begin
            armed <= 1'b1;
        end else if (press) begin
            armed <= 1'b0;
        end
    end

    // Mode FSM with registered reset outputs, word counter and error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_HOLD;
            hold_cnt   <= HOLD_LAST;
            upg_rst_q  <= 1'b1;
            cpu_rst_o  <= 1'b1;
            word_cnt_o <= 16'd0;
            err_o      <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (press) begin
                        state      <= ST_ARM;
                        upg_rst_q  <= 1'b0;
                        cpu_rst_o  <= 1'b1;
                        word_cnt_o <= 16'd0;
                        err_o      <= 1'b0;
                    end
                end
                ST_ARM, ST_PROG: begin
                    if (upg.upg_wen_i && (word_cnt_o != 16'hFFFF)) begin
                        word_cnt_o <= word_cnt_o + 16'd1;
                    end
                    if (upg.upg_done_i) begin
                        state     <= ST_HOLD;
                        hold_cnt  <= HOLD_LAST;
                        upg_rst_q <= 1'b1;
                        if (state == ST_ARM) begin
                            err_o <= 1'b1;
                        end
                    end else if (press) begin
                        state     <= ST_HOLD;
                        hold_cnt  <= HOLD_LAST;
                        upg_rst_q <= 1'b1;
                    end else if (upg.upg_wen_i && (state == ST_ARM)) begin
                        state <= ST_PROG;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == 8'd0) begin
                        state     <= ST_RUN;
                        cpu_rst_o <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= ST_HOLD;
                    hold_cnt  <= HOLD_LAST;
                    upg_rst_q <= 1'b1;
                    cpu_rst_o <= 1'b1;
                end
            endcase
        end
    end

    assign in_download   = (state == ST_ARM) || (state == ST_PROG);
    assign upg.upg_rst_o = upg_rst_q;
    assign upg.rom_wen_o = in_download & upg.upg_wen_i & ~upg.upg_adr_i[14];
    assign upg.ram_wen_o = in_download & upg.upg_wen_i &  upg.upg_adr_i[14];
    assign mode_o        = state;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer with a short debounce window and the
// default reset stretch: reset release, debounce filtering, a full download
// driven from a vector table, empty download, coincident events and reset
// in the middle of a download.
module tb_boot_sequencer;

    localparam int DEB  = 8;
    localparam int HOLD = 16;

    typedef struct {
        logic        done;
        logic        wen;
        logic [14:0] adr;
        logic [1:0]  mode;
        logic        upg_rst;
        logic        rom;
        logic        ram;
        logic [15:0] cnt;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        start_pg;
    logic        cpu_rst_o;
    logic [1:0]  mode_o;
    logic [15:0] word_cnt_o;
    logic        err_o;

    int total;
    int bad;

    vec_t vecs [10];

    boot_sequencer_if upg_bus ();

    boot_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start_pg  (start_pg),
        .upg       (upg_bus),
        .cpu_rst_o (cpu_rst_o),
        .mode_o    (mode_o),
        .word_cnt_o(word_cnt_o),
        .err_o     (err_o)
    );

    // Free-running 100 MHz clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case something stalls beyond any sensible run length.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        upg_bus.upg_done_i = v.done;
        upg_bus.upg_wen_i  = v.wen;
        upg_bus.upg_adr_i  = v.adr;
    endtask

    task automatic pressFor(input int n);
        start_pg = 1'b1;
        repeat (n) step();
        start_pg = 1'b0;
        repeat (4) step();
    endtask

    task automatic waitMode(input string name, input logic [1:0] target, input int budget);
        int n;
        n = 0;
        while ((mode_o !== target) && (n < budget)) begin
            step();
            n++;
        end
        checkOutput(name, 32'(mode_o), 32'(target));
    endtask

    initial begin
        int arm_entries;
        int hold_seen;
        logic [1:0] prev_mode;

        total = 0;
        bad   = 0;

        //               done  wen   adr       mode  urst  rom   ram   cnt
        vecs[0] = '{1'b0, 1'b1, 15'h0000, 2'd1, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 1'b0, 15'h0000, 2'd2, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[2] = '{1'b0, 1'b1, 15'h0001, 2'd2, 1'b0, 1'b1, 1'b0, 16'd1};
        vecs[3] = '{1'b0, 1'b1, 15'h0002, 2'd2, 1'b0, 1'b1, 1'b0, 16'd2};
        vecs[4] = '{1'b0, 1'b1, 15'h4000, 2'd2, 1'b0, 1'b0, 1'b1, 16'd3};
        vecs[5] = '{1'b0, 1'b0, 15'h4000, 2'd2, 1'b0, 1'b0, 1'b0, 16'd4};
        vecs[6] = '{1'b0, 1'b1, 15'h4001, 2'd2, 1'b0, 1'b0, 1'b1, 16'd4};
        vecs[7] = '{1'b0, 1'b0, 15'h0000, 2'd2, 1'b0, 1'b0, 1'b0, 16'd5};
        vecs[8] = '{1'b1, 1'b0, 15'h0000, 2'd2, 1'b0, 1'b0, 1'b0, 16'd5};
        vecs[9] = '{1'b1, 1'b1, 15'h0000, 2'd3, 1'b1, 1'b0, 1'b0, 16'd5};

        reset              = 1'b1;
        start_pg           = 1'b0;
        upg_bus.upg_done_i = 1'b0;
        upg_bus.upg_wen_i  = 1'b0;
        upg_bus.upg_adr_i  = 15'h0000;

        // Reset state, including no enables while held in reset.
        repeat (3) step();
        upg_bus.upg_wen_i = 1'b1;
        #1;
        checkOutput("rst_mode", 32'(mode_o), 32'd3);
        checkOutput("rst_upg_rst", 32'(upg_bus.upg_rst_o), 32'd1);
        checkOutput("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
        checkOutput("rst_cnt", 32'(word_cnt_o), 32'd0);
        checkOutput("rst_err", 32'(err_o), 32'd0);
        checkOutput("rst_rom_wen", 32'(upg_bus.rom_wen_o), 32'd0);
        upg_bus.upg_wen_i = 1'b0;

        // CPU released exactly HOLD edges after reset falls.
        reset = 1'b0;
        repeat (HOLD - 1) step();
        checkOutput("rel_cpu_rst_before", 32'(cpu_rst_o), 32'd1);
        checkOutput("rel_mode_before", 32'(mode_o), 32'd3);
        step();
        checkOutput("rel_cpu_rst_after", 32'(cpu_rst_o), 32'd0);
        checkOutput("rel_mode_after", 32'(mode_o), 32'd0);
        checkOutput("rel_upg_rst", 32'(upg_bus.upg_rst_o), 32'd1);

        // Writes while running never reach memory.
        upg_bus.upg_wen_i = 1'b1;
        upg_bus.upg_adr_i = 15'h0000;
        #1;
        checkOutput("run_rom_wen", 32'(upg_bus.rom_wen_o), 32'd0);
        upg_bus.upg_adr_i = 15'h4000;
        #1;
        checkOutput("run_ram_wen", 32'(upg_bus.ram_wen_o), 32'd0);
        step();
        upg_bus.upg_wen_i = 1'b0;
        checkOutput("run_cnt", 32'(word_cnt_o), 32'd0);

        // Short glitch is filtered out.
        start_pg = 1'b1;
        repeat (5) step();
        start_pg = 1'b0;
        repeat (20) step();
        checkOutput("short_pulse_mode", 32'(mode_o), 32'd0);

        // 20-cycle press: ARM on the 10th edge after the button rises.
        start_pg = 1'b1;
        repeat (9) step();
        checkOutput("press_lat_before", 32'(mode_o), 32'd0);
        step();
        checkOutput("press_lat_mode", 32'(mode_o), 32'd1);
        checkOutput("press_upg_rst", 32'(upg_bus.upg_rst_o), 32'd0);
        checkOutput("press_cpu_rst", 32'(cpu_rst_o), 32'd1);
        repeat (10) step();
        start_pg = 1'b0;
        repeat (4) step();
        checkOutput("press_once_mode", 32'(mode_o), 32'd1);

        // Download from the vector table.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("dl%0d_mode", i), 32'(mode_o), 32'(vecs[i].mode));
            checkOutput($sformatf("dl%0d_upg_rst", i), 32'(upg_bus.upg_rst_o), 32'(vecs[i].upg_rst));
            checkOutput($sformatf("dl%0d_rom", i), 32'(upg_bus.rom_wen_o), 32'(vecs[i].rom));
            checkOutput($sformatf("dl%0d_ram", i), 32'(upg_bus.ram_wen_o), 32'(vecs[i].ram));
            checkOutput($sformatf("dl%0d_cnt", i), 32'(word_cnt_o), 32'(vecs[i].cnt));
            step();
        end
        upg_bus.upg_wen_i = 1'b0;
        repeat (HOLD - 2) step();
        checkOutput("dl_hold_mode", 32'(mode_o), 32'd3);
        checkOutput("dl_hold_cpu_rst", 32'(cpu_rst_o), 32'd1);
        step();
        checkOutput("dl_run_mode", 32'(mode_o), 32'd0);
        checkOutput("dl_run_cpu_rst", 32'(cpu_rst_o), 32'd0);
        checkOutput("dl_run_err", 32'(err_o), 32'd0);
        checkOutput("dl_run_cnt", 32'(word_cnt_o), 32'd5);
        repeat (3) step();
        checkOutput("done_in_run_mode", 32'(mode_o), 32'd0);
        upg_bus.upg_done_i = 1'b0;

        // Button held 100 cycles gives a single event.
        arm_entries = 0;
        hold_seen   = 0;
        prev_mode   = mode_o;
        start_pg    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if ((prev_mode != 2'd1) && (mode_o == 2'd1)) arm_entries++;
            if (mode_o == 2'd3) hold_seen++;
            prev_mode = mode_o;
        end
        start_pg = 1'b0;
        checkOutput("held_arm_entries", 32'(arm_entries), 32'd1);
        checkOutput("held_hold_cycles", 32'(hold_seen), 32'd0);
        checkOutput("held_mode", 32'(mode_o), 32'd1);
        checkOutput("held_cnt_cleared", 32'(word_cnt_o), 32'd0);
        repeat (4) step();

        // Empty download sets the sticky error flag.
        upg_bus.upg_done_i = 1'b1;
        step();
        upg_bus.upg_done_i = 1'b0;
        checkOutput("empty_mode", 32'(mode_o), 32'd3);
        checkOutput("empty_err", 32'(err_o), 32'd1);
        checkOutput("empty_upg_rst", 32'(upg_bus.upg_rst_o), 32'd1);
        waitMode("empty_to_run", 2'd0, 40);
        checkOutput("empty_err_sticky", 32'(err_o), 32'd1);
        pressFor(20);
        checkOutput("repress_mode", 32'(mode_o), 32'd1);
        checkOutput("repress_err", 32'(err_o), 32'd0);
        checkOutput("repress_cnt", 32'(word_cnt_o), 32'd0);

        // Write, done and press in the same PROG cycle.
        upg_bus.upg_wen_i = 1'b1;
        upg_bus.upg_adr_i = 15'h4005;
        #1;
        checkOutput("co_first_ram", 32'(upg_bus.ram_wen_o), 32'd1);
        step();
        upg_bus.upg_wen_i = 1'b0;
        checkOutput("co_prog_mode", 32'(mode_o), 32'd2);
        checkOutput("co_prog_cnt", 32'(word_cnt_o), 32'd1);
        start_pg = 1'b1;
        repeat (9) step();
        upg_bus.upg_wen_i  = 1'b1;
        upg_bus.upg_adr_i  = 15'h0010;
        upg_bus.upg_done_i = 1'b1;
        #1;
        checkOutput("co_rom_gated", 32'(upg_bus.rom_wen_o), 32'd1);
        checkOutput("co_mode_before", 32'(mode_o), 32'd2);
        step();
        upg_bus.upg_wen_i  = 1'b0;
        upg_bus.upg_done_i = 1'b0;
        start_pg           = 1'b0;
        checkOutput("co_mode_after", 32'(mode_o), 32'd3);
        checkOutput("co_cnt", 32'(word_cnt_o), 32'd2);
        checkOutput("co_err", 32'(err_o), 32'd0);
        waitMode("co_to_run", 2'd0, 40);

        // Reset in the middle of a write.
        pressFor(20);
        checkOutput("mid_arm_mode", 32'(mode_o), 32'd1);
        upg_bus.upg_wen_i = 1'b1;
        upg_bus.upg_adr_i = 15'h0003;
        step();
        checkOutput("mid_prog_mode", 32'(mode_o), 32'd2);
        checkOutput("mid_prog_cnt", 32'(word_cnt_o), 32'd1);
        upg_bus.upg_adr_i = 15'h0004;
        #1;
        checkOutput("mid_rom_before", 32'(upg_bus.rom_wen_o), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rom_after", 32'(upg_bus.rom_wen_o), 32'd0);
        checkOutput("mid_mode", 32'(mode_o), 32'd3);
        checkOutput("mid_cnt", 32'(word_cnt_o), 32'd0);
        checkOutput("mid_upg_rst", 32'(upg_bus.upg_rst_o), 32'd1);
        checkOutput("mid_cpu_rst", 32'(cpu_rst_o), 32'd1);
        upg_bus.upg_wen_i = 1'b0;
        reset = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
# boot_sequencer

Run/program mode controller for the single-cycle CPU. It debounces the program-start button and generates the UART programmer reset. It holds the CPU in reset while a UART download is active and steers programmer write strobes to the instruction ROM or the data RAM. It then releases the CPU after a fixed reset stretch. Sits in the CPU top between the board button/reset, the `uart_bmpg_0` programmer, `programrom`/`dmemory32` write enables, and the `reset` inputs of `Ifetc32`/`Idecode32`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive synchronized-high cycles required to accept a `start_pg` press (10 ms at 100 MHz); range 2..2^20.
- `HOLD_CYCLES`, default 16: CPU reset stretch after leaving programming or after `reset`; range 1..255.

Ports:
- `clock`, in, 1: single clock, all state on rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `start_pg`, in, 1: raw program-start button, asynchronous to `clock`.
- `upg_done_i`, in, 1: programmer download complete (level).
- `upg_wen_i`, in, 1: programmer write strobe, one cycle per word.
- `upg_adr_i`, in, 15: programmer word address; bit 14 = 1 selects RAM, 0 selects ROM.
- `upg_rst_o`, out, 1: programmer reset, active-high.
- `cpu_rst_o`, out, 1: CPU reset, active-high.
- `rom_wen_o`, out, 1: gated ROM write enable.
- `ram_wen_o`, out, 1: gated RAM write enable.
- `mode_o`, out, 2: current state code.
- `word_cnt_o`, out, 16: words written in the current/last session.
- `err_o`, out, 1: sticky empty-download flag.

## Operation
- `start_pg` passes a 2-flop synchronizer. A 20-bit debounce counter increments while the synchronized level is 1 and clears when it is 0.
- A press event is a one-cycle pulse, generated when the counter reaches `DEBOUNCE_CYCLES-1`. It re-arms only after the synchronized level returns to 0, so a held button gives exactly one event.
- States and codes: RUN=00, ARM=01, PROG=10, HOLD=11.
- RUN
  - press -> ARM; clears `word_cnt_o` and `err_o`.
  - writes and `upg_done_i` ignored.
- ARM
  - `upg_wen_i` -> PROG; this write counts.
  - `upg_done_i` -> HOLD, with `err_o` set (empty download).
  - press -> HOLD (abort); `err_o` unchanged.
- PROG
  - every `upg_wen_i` increments `word_cnt_o`, saturating at 0xFFFF.
  - `upg_done_i` -> HOLD.
  - press -> HOLD (abort).
- HOLD
  - a hold counter loads `HOLD_CYCLES-1` on entry and decrements each cycle; at 0 -> RUN.
  - press and writes ignored.
- Priority when events coincide in ARM/PROG: `upg_done_i` > press > `upg_wen_i`. A write coinciding with done or press is still gated through to memory and still counted.
- Registered outputs:
  - `upg_rst_o` = 0 in ARM/PROG, 1 in RUN/HOLD.
  - `cpu_rst_o` = 0 only in RUN.
  - `mode_o` = state code.
- Combinational outputs:
  - `rom_wen_o` = `upg_wen_i & ~upg_adr_i[14]`, only in ARM/PROG.
  - `ram_wen_o` = `upg_wen_i & upg_adr_i[14]`, only in ARM/PROG.
  - Both are 0 in RUN/HOLD.

## Timing
- Reset values:
  - state = HOLD, hold counter = `HOLD_CYCLES-1`.
  - `upg_rst_o`=1, `cpu_rst_o`=1, `mode_o`=11.
  - `word_cnt_o`=0, `err_o`=0.
  - synchronizer and debounce counter = 0, re-arm latch set.
- After `reset` deasserts, the CPU is released exactly `HOLD_CYCLES` clock edges later.
- Press latency: `start_pg` rising, plus 2 sync cycles, plus `DEBOUNCE_CYCLES` cycles gives the press pulse. ARM and `upg_rst_o`=0 follow on the next edge.
- `upg_done_i` sampled in PROG at edge N: HOLD at N+1, `upg_rst_o`=1 at N+1, `cpu_rst_o` falls at N+1+`HOLD_CYCLES`.
- `word_cnt_o` updates on the edge after the strobe. Enable gating is zero-latency.
- `upg_done_i` staying high in HOLD/RUN has no effect; only ARM/PROG sample it.
- `reset` mid-download forces HOLD immediately (async), and in-flight write enables drop to 0.

## Test plan
- Reset release with `HOLD_CYCLES`=16 -> `cpu_rst_o` stays 1 for 16 edges then 0, `mode_o`=00, `upg_rst_o`=1.
- `DEBOUNCE_CYCLES`=8:
  - 5-cycle `start_pg` pulse -> no state change.
  - 20-cycle pulse -> ARM entered once, `upg_rst_o`=0, `cpu_rst_o`=1.
  - holding high 100 cycles -> still one event.
- Download: ARM, then 3 writes at 0x0000/0x0001/0x0002 and 2 writes at 0x4000/0x4001 -> 3 `rom_wen_o` pulses, 2 `ram_wen_o` pulses, `word_cnt_o`=5. `upg_done_i` -> HOLD, then RUN after 16 cycles, `err_o`=0.
- Empty download: ARM, then `upg_done_i` with no writes -> HOLD, `err_o`=1. Next press clears `err_o` and `word_cnt_o`.
- Coincidence: in PROG, `upg_wen_i`, `upg_done_i` and press in the same cycle -> write gated and counted, next state HOLD, `err_o` unchanged.
- `reset` asserted mid-PROG during a write -> `rom_wen_o`=0 immediately, `mode_o`=11, `word_cnt_o`=0. Writes while in RUN produce no enables.
